chunked_subtractor: RTL
=======================

CHUNKED_SUBTRACTOR -- requirements
Module: chunked_subtractor

Interface
REQ-001 SHALL have parameter cascade_size, default 4, meaning the number of bits subtracted per clock cycle (chunk width).
REQ-002 SHALL have parameter word_width, default 16, meaning the operand and result width; word_width SHALL be a multiple of cascade_size.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port RESET, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port IN_VALID, input, 1, meaning the operands are presented.
REQ-006 SHALL have port IN_READY, output, 1, meaning the block can accept operands.
REQ-007 SHALL have port A, input, word_width, the minuend.
REQ-008 SHALL have port B, input, word_width, the subtrahend.
REQ-009 SHALL have port B_IN, input, 1, the borrow-in.
REQ-010 SHALL have port OUT_VALID, output, 1, meaning a result is held.
REQ-011 SHALL have port OUT_READY, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port R, output, word_width, the result A - B - B_IN modulo 2^word_width.
REQ-013 SHALL have port B_OUT, output, 1, the borrow-out (1 when unsigned A < B + B_IN).
REQ-014 SHALL have port OVF, output, 1, the two's-complement signed overflow of the result.

Function
REQ-015 SHALL have FSM states IDLE, RUN and DONE; N = word_width/cascade_size.
REQ-016 IN_READY SHALL be 1 only in IDLE; OUT_VALID SHALL be 1 only in DONE.
REQ-017 In IDLE, when IN_VALID=1, SHALL register A, B and B_IN, clear the chunk counter, and go to RUN.
REQ-018 In RUN, on each edge, SHALL subtract chunk k (bits k*cascade_size upward) with the registered borrow, store the chunk result, update the borrow, and increment k.
REQ-019 The edge that processes chunk N-1 SHALL move the FSM to DONE, so OUT_VALID rises exactly N edges after the accepting edge.
REQ-020 R, B_OUT and OVF SHALL be stable for as long as the FSM is in DONE.
REQ-021 In DONE with OUT_READY=1, SHALL return to IDLE; no new operand SHALL be accepted on that same edge, so minimum throughput is one operation per N+2 cycles.
REQ-022 In DONE with OUT_READY=0, SHALL hold indefinitely.
REQ-023 SHALL ignore IN_VALID outside IDLE and SHALL ignore changes on A, B and B_IN after acceptance.
REQ-024 The chunk counter SHALL be clog2(N)+1 bits wide and SHALL never wrap within an operation.
REQ-025 When N=1, SHALL still pass through RUN for one cycle.

Reset
REQ-026 While RESET=1, on each edge, SHALL set the FSM to IDLE, clear the counter, and clear the borrow register.
REQ-027 After reset, outputs SHALL be IN_READY=1, OUT_VALID=0, R=0, B_OUT=0 and OVF=0.
REQ-028 RESET during RUN or DONE SHALL discard the operation; no OUT_VALID pulse SHALL follow.
REQ-029 RESET SHALL take priority over all handshakes.

Configuration
REQ-030 Macro CHUNKED_SUBTRACTOR_OVF_EN, when defined, SHALL compute OVF = (A[msb] != B[msb]) && (R[msb] != A[msb]), registered and valid in DONE.
REQ-031 When CHUNKED_SUBTRACTOR_OVF_EN is undefined, OVF SHALL be tied to 0 with no overflow logic, and all other behaviour SHALL be unchanged.

Structure
REQ-032 Package chunked_subtractor_pkg SHALL hold the FSM state enum typedef (IDLE/RUN/DONE).
REQ-033 SHALL have a combinational sub-module sub_chunk (cascade_size-bit A, B and borrow-in; difference and borrow-out), instantiated once and reused across cycles.
REQ-034 SHALL include an elaboration-time check that rejects word_width % cascade_size != 0.

Verification (word_width=8, cascade_size=2, N=4)
REQ-035 Bench SHALL drive A=0x50, B=0x20, B_IN=0 and require R=0x30, B_OUT=0, OVF=0, with OUT_VALID rising 4 edges after acceptance.
REQ-036 Bench SHALL drive A=0x00, B=0x01 and require R=0xFF, B_OUT=1, OVF=0.
REQ-037 Bench SHALL drive A=0x80, B=0x01 with the macro defined and require R=0x7F, OVF=1; with the macro undefined, require OVF=0.
REQ-038 Bench SHALL drive A=0x05, B=0x05, B_IN=1 and require R=0xFF, B_OUT=1.
REQ-039 Bench SHALL hold OUT_READY=0 for 10 cycles in DONE while A and B toggle, and require R to hold its value and IN_READY=0; after OUT_READY=1, require IDLE on the next edge.
REQ-040 Bench SHALL assert RESET on the 2nd RUN cycle and require OUT_VALID=0 and IN_READY=1 on the next edge, then a clean 0x50-0x20 operation.

Source files
------------

// File: rtl/chunked_subtractor_pkg.sv
// Shared types and helpers for the chunked (multi-cycle) subtractor.
package chunked_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of a - b: operands differ in sign and the result sign follows b.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/chunked_subtractor_sub_chunk.sv
// Combinational cascade_size-bit subtract slice: {bout, d} = a - b - bin.
module chunked_subtractor_sub_chunk #(
  parameter int width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             bin,
  output logic [width-1:0] d,
  output logic             bout
);

  logic [width:0] wide_s;

  // One extra bit captures the borrow: it is set exactly when the true difference is negative.
  always_comb begin
    wide_s = {1'b0, a} - {1'b0, b} - {{width{1'b0}}, bin};
    d      = wide_s[width-1:0];
    bout   = wide_s[width];
  end

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: R = A - B - B_IN, one cascade_size-bit chunk per clock.
// Define CHUNKED_SUBTRACTOR_OVF_EN to enable the signed-overflow flag OVF.
module chunked_subtractor
  import chunked_subtractor_pkg::*;
#(
  parameter int cascade_size = 4,
  parameter int word_width   = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [word_width-1:0] A,
  input  logic [word_width-1:0] B,
  input  logic                  B_IN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [word_width-1:0] R,
  output logic                  B_OUT,
  output logic                  OVF
);

  localparam int N  = word_width / cascade_size;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = (word_width > 1) ? $clog2(word_width) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((cascade_size < 1) || (word_width % cascade_size != 0)) begin : g_width_check
    $error("chunked_subtractor: word_width must be a positive multiple of cascade_size");
  end

  state_t                  state_r;
  logic [CW-1:0]           cnt_r;
  logic [word_width-1:0]   a_r;
  logic [word_width-1:0]   b_r;
  logic                    borrow_r;
  logic [word_width-1:0]   res_r;
  logic                    b_out_r;
  logic                    in_ready_r;
  logic                    out_valid_r;

  logic [IW-1:0]           base_s;
  logic [cascade_size-1:0] a_chunk_s;
  logic [cascade_size-1:0] b_chunk_s;
  logic [cascade_size-1:0] diff_s;
  logic                    bout_s;

  // Select the operand chunk addressed by the counter for the shared slice.
  always_comb begin
    base_s    = IW'(cnt_r) * IW'(cascade_size);
    a_chunk_s = a_r[base_s +: cascade_size];
    b_chunk_s = b_r[base_s +: cascade_size];
  end

  chunked_subtractor_sub_chunk #(
    .width(cascade_size)
  ) sub_chunk (
    .a   (a_chunk_s),
    .b   (b_chunk_s),
    .bin (borrow_r),
    .d   (diff_s),
    .bout(bout_s)
  );

`ifdef CHUNKED_SUBTRACTOR_OVF_EN
  logic ovf_r;
`endif

  // Control FSM, chunk datapath and registered handshake/result outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      a_r         <= {word_width{1'b0}};
      b_r         <= {word_width{1'b0}};
      borrow_r    <= 1'b0;
      res_r       <= {word_width{1'b0}};
      b_out_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (IN_VALID) begin
            a_r        <= A;
            b_r        <= B;
            borrow_r   <= B_IN;
            cnt_r      <= {CW{1'b0}};
            state_r    <= RUN;
            in_ready_r <= 1'b0;
          end
        end
        RUN: begin
          res_r[base_s +: cascade_size] <= diff_s;
          borrow_r <= bout_s;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            // Final chunk carries the sign bits, so the flags are finalised here.
            b_out_r     <= bout_s;
            state_r     <= DONE;
            out_valid_r <= 1'b1;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
            ovf_r <= sub_overflow(a_r[word_width-1], b_r[word_width-1], diff_s[cascade_size-1]);
`endif
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign R         = res_r;
  assign B_OUT     = b_out_r;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
  assign OVF       = ovf_r;
`else
  assign OVF       = 1'b0;
`endif

endmodule
